// File: rtl/mutex_pkg.sv
// Shared types and default parameters for the mutex requester-side lock controller.
package mutex_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_HOLD,
    ST_RELEASE,
    ST_BACKOFF
  } mutex_client_state_t;

  localparam int DEF_HOLD_W    = 8;
  localparam int DEF_TIMEOUT   = 16;
  localparam int DEF_BACKOFF   = 4;
  localparam int DEF_MAX_RETRY = 3;

endpackage

// File: rtl/mutex_down_counter.sv
// Loadable down counter that saturates at zero and flags the terminal value.
module mutex_down_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/mutex_client.sv
// Requester-side lock controller: request, hold for N cycles, release; timeout with retry.
// Optional retry/backoff path is enabled by defining MUTEX_CLIENT_RETRY_EN.
module mutex_client
  import mutex_pkg::*;
#(
  parameter int HOLD_W    = DEF_HOLD_W,
  parameter int TIMEOUT   = DEF_TIMEOUT,
  parameter int BACKOFF   = DEF_BACKOFF,
  parameter int MAX_RETRY = DEF_MAX_RETRY
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              acq_valid,
  input  logic [HOLD_W-1:0] acq_len,
  output logic              acq_ready,
  output logic              arb_req,
  input  logic              arb_grant,
  output logic              owner,
  output logic              done,
  output logic              timeout_err,
  output logic              lost_grant,
  output logic [2:0]        state_dbg
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("mutex_client: TIMEOUT must be at least 2");
  end
  if ((BACKOFF < 1) || (MAX_RETRY < 1)) begin : g_bad_retry
    $error("mutex_client: BACKOFF and MAX_RETRY must be at least 1");
  end

  mutex_client_state_t state, state_n;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [HOLD_W-1:0]   len_q;
  logic wait_inc, wait_clr, len_load, hold_load, hold_dec, hold_zero;
  logic terr_n, lost_n;

`ifdef MUTEX_CLIENT_RETRY_EN
  localparam int RETRY_W = $clog2(MAX_RETRY + 1);
  localparam int BO_W    = $clog2(BACKOFF + 1);
  logic [RETRY_W-1:0] retry_cnt;
  logic retry_inc, retry_clr, bo_load, bo_dec, bo_zero;
`endif

  always_comb begin
    state_n   = state;
    wait_inc  = 1'b0;
    wait_clr  = 1'b0;
    len_load  = 1'b0;
    hold_load = 1'b0;
    hold_dec  = 1'b0;
    terr_n    = 1'b0;
    lost_n    = 1'b0;
`ifdef MUTEX_CLIENT_RETRY_EN
    retry_inc = 1'b0;
    retry_clr = 1'b0;
    bo_load   = 1'b0;
    bo_dec    = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        if (acq_valid) begin
          state_n  = ST_REQ;
          len_load = 1'b1;
          wait_clr = 1'b1;
`ifdef MUTEX_CLIENT_RETRY_EN
          retry_clr = 1'b1;
`endif
        end
      end
      ST_REQ: begin
        // A grant on the final wait cycle takes precedence over the timeout.
        if (arb_grant) begin
          state_n   = ST_HOLD;
          hold_load = 1'b1;
        end else begin
          wait_inc = 1'b1;
          if (wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
`ifdef MUTEX_CLIENT_RETRY_EN
            retry_inc = 1'b1;
            if ((int'(retry_cnt) + 1) < MAX_RETRY) begin
              state_n = ST_BACKOFF;
              bo_load = 1'b1;
            end else begin
              state_n = ST_IDLE;
              terr_n  = 1'b1;
            end
`else
            state_n = ST_IDLE;
            terr_n  = 1'b1;
`endif
          end
        end
      end
      ST_HOLD: begin
        if (!arb_grant) begin
          state_n = ST_IDLE;
          lost_n  = 1'b1;
        end else if (hold_zero) begin
          state_n = ST_RELEASE;
        end else begin
          hold_dec = 1'b1;
        end
      end
      ST_RELEASE: state_n = ST_IDLE;
`ifdef MUTEX_CLIENT_RETRY_EN
      ST_BACKOFF: begin
        if (bo_zero) begin
          state_n  = ST_REQ;
          wait_clr = 1'b1;
        end else begin
          bo_dec = 1'b1;
        end
      end
`endif
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Outputs are decoded from the next state so they are registered yet aligned with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acq_ready   <= 1'b1;
      arb_req     <= 1'b0;
      owner       <= 1'b0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
      lost_grant  <= 1'b0;
    end else begin
      acq_ready   <= (state_n == ST_IDLE);
      arb_req     <= (state_n == ST_REQ) || (state_n == ST_HOLD);
      owner       <= (state_n == ST_HOLD);
      done        <= (state_n == ST_RELEASE);
      timeout_err <= terr_n;
      lost_grant  <= lost_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
      len_q    <= '0;
    end else begin
      if (wait_clr) begin
        wait_cnt <= '0;
      end else if (wait_inc && (wait_cnt != WAIT_W'(TIMEOUT))) begin
        wait_cnt <= wait_cnt + WAIT_W'(1);
      end
      if (len_load) begin
        len_q <= (acq_len == '0) ? HOLD_W'(1) : acq_len;
      end
    end
  end

  // Loaded with len-1 so the counter reaches zero on the last owned cycle.
  mutex_down_counter #(.W(HOLD_W)) u_hold_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (hold_load),
    .load_val (len_q - HOLD_W'(1)),
    .dec      (hold_dec),
    .zero     (hold_zero)
  );

`ifdef MUTEX_CLIENT_RETRY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retry_cnt <= '0;
    end else if (retry_clr) begin
      retry_cnt <= '0;
    end else if (retry_inc && (retry_cnt != RETRY_W'(MAX_RETRY))) begin
      retry_cnt <= retry_cnt + RETRY_W'(1);
    end
  end

  mutex_down_counter #(.W(BO_W)) u_backoff_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (bo_load),
    .load_val (BO_W'(BACKOFF - 1)),
    .dec      (bo_dec),
    .zero     (bo_zero)
  );
`endif

  assign state_dbg = state;

endmodule

// File: doc/mutex_client.md
# mutex_client

Requester-side lock controller for the shared-resource arbiters (priority and round-robin mutexes). A local agent asks for exclusive access for N cycles. The block drives one arbiter request line, waits for the grant, and asserts ownership for exactly N cycles. It then releases the lock. Requests with no grant time out, back off and retry, so a starved client cannot hang its agent.

## Interface
- `HOLD_W`, 8: width of the hold-length field.
- `TIMEOUT`, 16: consecutive REQ cycles without a grant before a timeout; must be ≥ 2.
- `BACKOFF`, 4: cycles with `arb_req` low after a timeout; must be ≥ 1.
- `MAX_RETRY`, 3: timeouts tolerated before the acquisition is abandoned; must be ≥ 1.

Ports (name, direction, width, meaning):
- `clk` in 1: single clock.
- `rst` in 1: asynchronous, active-high reset.
- `acq_valid` in 1: agent requests an acquisition.
- `acq_len` in HOLD_W: number of ownership cycles; 0 is treated as 1.
- `acq_ready` out 1: block is idle and can accept an acquisition.
- `arb_req` out 1: request line to the arbiter.
- `arb_grant` in 1: grant line from the arbiter.
- `owner` out 1: the agent holds the lock in this cycle.
- `done` out 1: one-cycle pulse when the lock is released normally.
- `timeout_err` out 1: one-cycle pulse when an acquisition is abandoned.
- `lost_grant` out 1: one-cycle pulse when the arbiter deasserts the grant during HOLD.

## Operation
- States: IDLE, REQ, HOLD, RELEASE, BACKOFF.
- IDLE:
  - `acq_ready`=1.
  - On `acq_valid`, latch `max(acq_len,1)`, clear the retry count, go to REQ.
- REQ:
  - `arb_req`=1 and the wait counter increments.
  - If `arb_grant` is sampled high, go to HOLD and load the hold counter.
  - Else, if the wait counter reaches TIMEOUT, increment the retry count.
  - If the retry count is now < MAX_RETRY, go to BACKOFF. Otherwise pulse `timeout_err` and go to IDLE.
- BACKOFF: `arb_req`=0 for BACKOFF cycles, then REQ with the wait counter cleared.
- HOLD:
  - `arb_req`=1 and `owner`=1; the hold counter decrements each cycle.
  - After the last owned cycle, go to RELEASE.
  - If `arb_grant` is sampled low while in HOLD, pulse `lost_grant`, drop `owner` next cycle and go to IDLE. No `done` pulse.
- RELEASE:
  - `arb_req`=0, `done`=1 for one cycle, then IDLE.
  - This guarantees one request-low cycle, which the round-robin arbiter needs to advance.
- Grant arriving in the same cycle the wait counter hits TIMEOUT: the grant wins and the block goes to HOLD.
- `acq_valid` outside IDLE is ignored; `acq_ready`=0 in every non-IDLE state.
- Counter widths:
  - wait counter: $clog2(TIMEOUT+1)
  - backoff counter: $clog2(BACKOFF+1)
  - retry counter: $clog2(MAX_RETRY+1)
  - hold counter: HOLD_W
  - No counter wraps. Each saturates at its terminal value and state exits on that value.

## Timing
- All outputs are registered. Reset values:
  - `acq_ready`=1
  - `arb_req`=0, `owner`=0, `done`=0, `timeout_err`=0, `lost_grant`=0
  - state IDLE, all counters 0
- Acquisition accepted at edge T: `arb_req`=1 from T+1.
- Grant first sampled high at edge G: `owner`=1 for cycles G+1 .. G+len.
- After the last owned cycle: `arb_req`=0 and `done`=1 in cycle G+len+1; `acq_ready`=1 in G+len+2.
- Minimum latency from accept to first owned cycle is 2 cycles, because the arbiter grant is registered.
- Timeout: `arb_req` is high for exactly TIMEOUT cycles per attempt and low for exactly BACKOFF cycles between attempts.
- Reset mid-operation: all outputs return to reset values immediately (asynchronous). No `done` pulse and no error pulse is produced.

## Configuration
- `MUTEX_CLIENT_RETRY_EN` defined: the BACKOFF state and the retry counter exist, and behaviour is as above.
- Not defined: BACKOFF and the retry counter are removed. The first timeout pulses `timeout_err` and returns to IDLE. MAX_RETRY and BACKOFF are ignored.

## Structure
- Shared package `mutex_pkg`:
  - `mutex_client_state_t` enum (IDLE, REQ, HOLD, RELEASE, BACKOFF).
  - Default localparams for TIMEOUT, BACKOFF and MAX_RETRY.
- One sub-module, `mutex_down_counter`: a parameterised load/decrement/terminal-flag counter, instantiated for the hold and backoff counters. The wait and retry counters stay inline.

## Test plan
- Immediate grant: acq_len=3, grant high 1 cycle after `arb_req` → `owner` high for 3 cycles, then `done` with `arb_req`=0 in the next cycle.
- acq_len=0 → exactly 1 owned cycle, then `done`.
- Starved, TIMEOUT=16, BACKOFF=4, MAX_RETRY=3, grant never asserts → three 16-cycle `arb_req` windows separated by two 4-cycle gaps, then one `timeout_err` pulse and `acq_ready`=1.
- Grant arrives on the 16th REQ cycle → HOLD entered, no retry counted.
- Grant dropped after 2 of 5 owned cycles → `lost_grant` pulse, `owner` low next cycle, no `done`.
- Two clients behind the round-robin arbiter, both requesting len=2 back-to-back → ownership alternates and `owner` is never high on both simultaneously.
- Additional, outside the core set: `rst` asserted mid-HOLD → `owner` and `arb_req` drop asynchronously.
